// File: rtl/perf_counter_sampler_if.sv
// Counter-port (addr/we/data) and sample-stream signals for perf_counter_sampler.
// master: the sampler side; slave: the counter bank plus the trace sink.
interface perf_counter_sampler_if;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [4:0]  addr_o;
  logic        we_o;
  logic [63:0] wdata_o;
  logic [63:0] rdata_i;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic [63:0] sample_data_o;
  logic [4:0]  sample_idx_o;
  logic [15:0] sample_epoch_o;
  logic        sample_last_o;
  logic [7:0]  sample_core_o;

  modport master (
    output bus_req_o, addr_o, we_o, wdata_o,
    output sample_valid_o, sample_data_o, sample_idx_o, sample_epoch_o,
    output sample_last_o, sample_core_o,
    input  bus_gnt_i, rdata_i, sample_ready_i
  );

  modport slave (
    input  bus_req_o, addr_o, we_o, wdata_o,
    input  sample_valid_o, sample_data_o, sample_idx_o, sample_epoch_o,
    input  sample_last_o, sample_core_o,
    output bus_gnt_i, rdata_i, sample_ready_i
  );
endinterface

// File: rtl/perf_counter_sampler.sv
// Periodic/triggered perf-counter sampler: reads a counter window into a FIFO drained by a stream.
// Optional read-and-clear of each counter on its beat: define PERF_SAMPLER_CLEAR_EN.
module perf_counter_sampler #(
  parameter int unsigned CORE_ADDR  = 1,
  parameter int unsigned FIRST_IDX  = 0,
  parameter int unsigned NUM_CNT    = 14,
  parameter int unsigned INTERVAL   = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   trigger_i,
  input  logic                   debug_mode_i,
  perf_counter_sampler_if.master bus,
  output logic                   overrun_o,
  output logic                   busy_o
);
  localparam int unsigned TW = $clog2(INTERVAL);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, READ} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  idx;
    logic [15:0] epoch;
    logic        last;
  } sample_t;

  logic [TW-1:0] timer;
  logic          tick;
  state_t        state;
  logic [4:0]    idx;
  logic [15:0]   epoch;
  logic [4:0]    addr;
  logic          beat;
  logic          last_beat;

  sample_t       mem [FIFO_DEPTH];
  logic [PW:0]   wptr;
  logic [PW:0]   rptr;
  logic          full;
  logic          empty;
  logic          pop;
  sample_t       head;

  assign tick      = enable_i && !debug_mode_i && (timer == TW'(INTERVAL - 1));
  assign addr      = 5'(FIRST_IDX) + idx;
  assign last_beat = (idx == 5'(NUM_CNT - 1));
  assign empty     = (wptr == rptr);
  assign full      = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);
  // Capacity is judged before any same-cycle pop, so a full FIFO stalls the beat.
  assign beat      = (state == READ) && bus.bus_gnt_i && !full;
  assign pop       = !empty && bus.sample_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer <= '0;
    end else if (!enable_i) begin
      timer <= '0;
    end else if (!debug_mode_i) begin
      timer <= tick ? '0 : timer + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      idx       <= '0;
      epoch     <= '0;
      overrun_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick || trigger_i) begin
            state <= READ;
            idx   <= '0;
          end
        end
        READ: begin
          if (beat) begin
            if (last_beat) begin
              state <= IDLE;
              idx   <= '0;
              epoch <= epoch + 16'd1;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Disabling wins over a request dropped in the same cycle.
      if (!enable_i) begin
        overrun_o <= 1'b0;
      end else if ((state == READ) && (tick || trigger_i)) begin
        overrun_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (beat) begin
        mem[wptr[PW-1:0]] <= '{data: bus.rdata_i, idx: addr, epoch: epoch, last: last_beat};
        wptr              <= wptr + (PW+1)'(1);
      end
      if (pop) begin
        rptr <= rptr + (PW+1)'(1);
      end
    end
  end

  assign head = mem[rptr[PW-1:0]];

  // Sample fields are forced to zero while empty so stale storage never leaks out.
  always_comb begin
    bus.sample_valid_o = !empty;
    bus.sample_data_o  = '0;
    bus.sample_idx_o   = '0;
    bus.sample_epoch_o = '0;
    bus.sample_last_o  = 1'b0;
    bus.sample_core_o  = '0;
    if (!empty) begin
      bus.sample_data_o  = head.data;
      bus.sample_idx_o   = head.idx;
      bus.sample_epoch_o = head.epoch;
      bus.sample_last_o  = head.last;
      bus.sample_core_o  = 8'(CORE_ADDR);
    end
  end

  assign bus.bus_req_o = (state == READ);
  assign bus.addr_o    = (state == READ) ? addr : '0;
  assign bus.wdata_o   = '0;
  assign busy_o        = (state == READ);

`ifdef PERF_SAMPLER_CLEAR_EN
  assign bus.we_o = beat;
`else
  assign bus.we_o = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Randomized bench for perf_counter_sampler against a queue-based model of the sampling rules.
// Also covers the read-and-clear build when PERF_SAMPLER_CLEAR_EN is defined.
module tb_perf_counter_sampler;
  localparam int CORE  = 300;
  localparam int FIRST = 2;
  localparam int NUM   = 6;
  localparam int INTV  = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] data;
    int          idx;
    int          epoch;
    bit          last;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n, en, trig, dbg, ovr, busy;
  logic [63:0] bank [32];
  logic clr_req;
  logic [4:0] clr_addr;

  int checks = 0;
  int errors = 0;

  int   m_timer, m_idx, m_epoch;
  bit   m_reading, m_ovr;
  smp_t q[$];

  perf_counter_sampler_if bus ();

  perf_counter_sampler #(
    .CORE_ADDR (CORE),
    .FIRST_IDX (FIRST),
    .NUM_CNT   (NUM),
    .INTERVAL  (INTV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (en),
    .trigger_i   (trig),
    .debug_mode_i(dbg),
    .bus         (bus.master),
    .overrun_o   (ovr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  assign bus.rdata_i = bank[bus.addr_o];

  // Counter bank write port: a clear lands at the edge where we_o is seen with grant.
  always @(posedge clk) begin
    clr_req  = bus.we_o & bus.bus_gnt_i;
    clr_addr = bus.addr_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_idx = 0; m_epoch = 0; m_reading = 0; m_ovr = 0;
    q.delete();
  endtask

  task automatic cycle(input bit e, input bit t, input bit d, input bit g, input bit r,
                       input bit rs, input bit bump);
    bit tick, full, beat, pop, last, exp_we;
    smp_t s;
    @(negedge clk);
    if (clr_req === 1'b1) bank[clr_addr] = '0;
    if (bump) begin
      int a = $urandom_range(31);
      bank[a] = bank[a] + 64'($urandom_range(1, 7));
    end
    en = e; trig = t; dbg = d; bus.bus_gnt_i = g; bus.sample_ready_i = r; rst_n = rs;
    #1;
    full = (q.size() >= DEPTH);
    beat = m_reading && g && !full;
`ifdef PERF_SAMPLER_CLEAR_EN
    exp_we = beat;
`else
    exp_we = 1'b0;
`endif
    chk("busy", 64'(busy), 64'(m_reading));
    chk("bus_req", 64'(bus.bus_req_o), 64'(m_reading));
    chk("addr", 64'(bus.addr_o), m_reading ? 64'(FIRST + m_idx) : 64'd0);
    chk("we", 64'(bus.we_o), 64'(exp_we));
    chk("wdata", bus.wdata_o, 64'd0);
    chk("overrun", 64'(ovr), 64'(m_ovr));
    chk("valid", 64'(bus.sample_valid_o), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("data", bus.sample_data_o, q[0].data);
      chk("idx", 64'(bus.sample_idx_o), 64'(q[0].idx));
      chk("epoch", 64'(bus.sample_epoch_o), 64'(q[0].epoch));
      chk("last", 64'(bus.sample_last_o), 64'(q[0].last));
      chk("core", 64'(bus.sample_core_o), 64'(CORE % 256));
    end else begin
      chk("idle_fields", {bus.sample_data_o[31:0], bus.sample_idx_o, bus.sample_epoch_o,
                          bus.sample_last_o, bus.sample_core_o[5:0]}, 64'd0);
    end

    if (!rs) begin
      model_reset();
    end else begin
      tick = e && !d && (m_timer == INTV - 1);
      pop  = (q.size() != 0) && r;
      last = (m_idx == NUM - 1);
      s    = '{data: bank[FIRST + m_idx], idx: FIRST + m_idx, epoch: m_epoch, last: last};
      if (pop) void'(q.pop_front());
      if (beat) q.push_back(s);
      if (m_reading && (tick || t)) m_ovr = 1;
      if (!e) m_ovr = 0;
      if (m_reading) begin
        if (beat) begin
          if (last) begin
            m_reading = 0; m_idx = 0; m_epoch = (m_epoch + 1) % 65536;
          end else begin
            m_idx++;
          end
        end
      end else if (tick || t) begin
        m_reading = 1; m_idx = 0;
      end
      if (!e) m_timer = 0;
      else if (!d) m_timer = (m_timer == INTV - 1) ? 0 : m_timer + 1;
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) bank[a] = 64'(a * 100);
    clr_req = 1'b0; clr_addr = '0;
    en = 0; trig = 0; dbg = 0; rst_n = 0;
    bus.bus_gnt_i = 0; bus.sample_ready_i = 0;
    repeat (3) @(negedge clk);
    model_reset();

    // reset held: everything idle and zero
    cycle(1, 0, 0, 1, 1, 0, 0);
    // periodic epochs with grant and ready held
    for (int i = 0; i < 70; i++) cycle(1, 0, 0, 1, 1, 1, 0);
    // backpressure on a triggered epoch
    cycle(0, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1, 1, 0);
    // grant gaps
    cycle(0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1'(i % 2 == 0), 1, 1, 0);
    // overrun by a second trigger, then clear by dropping enable
    cycle(1, 1, 0, 1, 1, 1, 0);
    cycle(1, 0, 0, 1, 1, 1, 0);
    cycle(1, 0, 0, 1, 1, 1, 0);
    cycle(1, 1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1, 1, 1, 0);
    // reset after two beats of an epoch
    cycle(0, 1, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1, 1, 0);
    // randomized traffic with counter activity
    for (int i = 0; i < 2000 && errors < 20; i++) begin
      cycle(1'($urandom_range(99) < 92), 1'($urandom_range(99) < 5),
            1'($urandom_range(99) < 10), 1'($urandom_range(99) < 70),
            1'($urandom_range(99) < 60), 1'($urandom_range(999) >= 3),
            1'($urandom_range(99) < 50));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
